// File: rtl/aes_mode_ctrl.sv
// Block-chaining front end for the AES-256 core: input FIFO, ECB/CBC(/CTR) chaining, output handshake.
// Optional feature macro: AES_MODE_CTRL_CTR_EN (CTR mode and its 128-bit counter incrementer).
module aes_mode_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic         encryp_decrypt,
    input  logic [255:0] cipher_key,
    input  logic [127:0] iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         cfg_err,
    output logic [127:0] core_data_in,
    output logic [255:0] core_key,
    output logic         core_encdec,
    output logic         core_en,
    output logic         core_rst_n,
    input  logic [127:0] core_data_out,
    input  logic         core_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] M_CBC = 2'b01;
`ifdef AES_MODE_CTRL_CTR_EN
    localparam logic [1:0] M_CTR = 2'b10;
`endif

    typedef enum logic [1:0] {IDLE, CLR, RUN, EMIT} state_t;
    state_t state, state_nxt;

    logic [127:0]          fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  last_stored;
    logic [1:0]            mode_q;
    logic                  enc_q;
    logic [255:0]          key_q;
    logic [127:0]          chain;
    logic                  mode_ok, push, pop, full, empty;
    logic [127:0]          head, result, chain_nxt;

    assign head     = fifo_data[rd_ptr];
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign in_ready = busy & ~full & ~last_stored;
    assign push     = in_valid & in_ready;
    assign pop      = (state == RUN) & core_done;
    assign core_key = key_q;

    always_comb begin
        case (mode)
            2'b00, 2'b01: mode_ok = 1'b1;
`ifdef AES_MODE_CTRL_CTR_EN
            M_CTR:        mode_ok = 1'b1;
`endif
            default:      mode_ok = 1'b0;
        endcase
    end

    // Chaining datapath; head and chain are stable for the whole CLR/RUN window.
    always_comb begin
        core_data_in = head;
        core_encdec  = enc_q;
        result       = core_data_out;
        chain_nxt    = chain;
        case (mode_q)
            M_CBC: begin
                if (enc_q) begin
                    core_data_in = head ^ chain;
                    chain_nxt    = core_data_out;
                end else begin
                    result    = core_data_out ^ chain;
                    chain_nxt = head;
                end
            end
`ifdef AES_MODE_CTRL_CTR_EN
            M_CTR: begin
                core_encdec  = 1'b1;
                core_data_in = chain;
                result       = core_data_out ^ head;
                chain_nxt    = chain + 128'd1;
            end
`endif
            default: ;
        endcase
        if (state == IDLE) begin
            core_data_in = '0;
            core_encdec  = 1'b0;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        out_valid  = 1'b0;
        core_en    = 1'b0;
        core_rst_n = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && mode_ok) state_nxt = CLR;
            end
            CLR:  if (!empty) state_nxt = RUN;
            RUN: begin
                core_en    = 1'b1;
                core_rst_n = 1'b1;
                if (core_done) state_nxt = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = out_last ? IDLE : CLR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (push) fifo_data[wr_ptr] <= in_data;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= IDLE;
            fifo_last   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            last_stored <= 1'b0;
            mode_q      <= '0;
            enc_q       <= 1'b0;
            key_q       <= '0;
            chain       <= '0;
            cfg_err     <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start && state == IDLE) begin
                if (mode_ok) begin
                    mode_q  <= mode;
                    enc_q   <= encryp_decrypt;
                    key_q   <= cipher_key;
                    chain   <= iv;
                    cfg_err <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
            if (push) begin
                fifo_last[wr_ptr] <= in_last;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                chain    <= chain_nxt;
                out_data <= result;
                out_last <= fifo_last[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
            // Further blocks wait until the message's final result has been taken.
            if (push && in_last)
                last_stored <= 1'b1;
            else if (state == EMIT && out_ready && out_last)
                last_stored <= 1'b0;
        end
    end
endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Bench for aes_mode_ctrl: behavioural stand-in cipher core with random latency, queue-based chaining model.
module tb_aes_mode_ctrl;
    localparam int FIFO_DEPTH = 4;

    logic         Clk = 1'b0, Rst = 1'b0;
    logic         start = 0, encryp_decrypt = 0, in_valid = 0, in_last = 0, out_ready = 0;
    logic [1:0]   mode = 0;
    logic [255:0] cipher_key = '0;
    logic [127:0] iv = '0, in_data = '0;
    logic         in_ready, out_valid, out_last, busy, cfg_err;
    logic [127:0] out_data, core_data_in, core_data_out;
    logic [255:0] core_key;
    logic         core_encdec, core_en, core_rst_n, core_done;

    aes_mode_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .mode(mode), .encryp_decrypt(encryp_decrypt),
        .cipher_key(cipher_key), .iv(iv), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .cfg_err(cfg_err),
        .core_data_in(core_data_in), .core_key(core_key), .core_encdec(core_encdec),
        .core_en(core_en), .core_rst_n(core_rst_n), .core_data_out(core_data_out),
        .core_done(core_done));

    always #5 Clk = ~Clk;

    int n_cmp = 0, n_bad = 0, n_pushed = 0;
    logic [127:0] blk [$];
    logic [127:0] exp_d [$];
    logic         exp_l [$];

    // Invertible stand-in for the AES core keyed by both key halves.
    function automatic logic [127:0] f_enc(input logic [127:0] d, input logic [255:0] k);
        logic [127:0] t;
        t = d ^ k[127:0];
        return {t[114:0], t[127:115]} + k[255:128];
    endfunction
    function automatic logic [127:0] f_dec(input logic [127:0] d, input logic [255:0] k);
        logic [127:0] t;
        t = d - k[255:128];
        return {t[12:0], t[127:13]} ^ k[127:0];
    endfunction
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    int unsigned ccnt = 0, clat = 1;
    always @(posedge Clk) begin
        if (!core_rst_n) begin
            ccnt <= 0;
            clat <= $urandom_range(4, 1);
        end else if (core_en && ccnt < clat) begin
            ccnt <= ccnt + 1;
        end
    end
    assign core_done     = core_rst_n && (ccnt == clat);
    assign core_data_out = !core_done ? '0 :
                           core_encdec ? f_enc(core_data_in, core_key) : f_dec(core_data_in, core_key);

    task automatic fill_blocks(input int n);
        blk.delete();
        for (int i = 0; i < n; i++) blk.push_back(rnd128());
    endtask

    // Message-level reference: expected results straight from the chaining rules.
    task automatic build_exp(input logic [1:0] m, input logic e, input logic [255:0] k, input logic [127:0] v);
        logic [127:0] x, p, r;
        x = v;
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < blk.size(); i++) begin
            p = blk[i];
            case (m)
                2'b00: r = e ? f_enc(p, k) : f_dec(p, k);
                2'b01: if (e) begin r = f_enc(p ^ x, k); x = r; end
                       else begin r = f_dec(p, k) ^ x; x = p; end
                default: begin r = f_enc(x, k) ^ p; x = x + 1; end
            endcase
            exp_d.push_back(r);
            exp_l.push_back(i == blk.size() - 1);
        end
    endtask

    task automatic do_start(input logic [1:0] m, input logic e, input logic [255:0] k, input logic [127:0] v);
        @(negedge Clk);
        start = 1; mode = m; encryp_decrypt = e; cipher_key = k; iv = v;
        @(negedge Clk);
        start = 0; mode = 2'($urandom); encryp_decrypt = 1'($urandom);
        cipher_key = {rnd128(), rnd128()}; iv = rnd128();
    endtask

    task automatic drive(input int vpct);
        int i = 0, cyc = 0;
        n_pushed = 0;
        while (i < blk.size() && cyc < 5000) begin
            @(negedge Clk);
            cyc++;
            in_valid = ($urandom_range(99) < vpct);
            in_data  = blk[i];
            in_last  = (i == blk.size() - 1);
            #3;
            if (in_valid && in_ready) begin i++; n_pushed++; end
        end
        @(negedge Clk);
        in_valid = 0; in_last = 0;
        n_cmp++;
        if (i != blk.size()) begin
            n_bad++;
            $display("FAIL drive_timeout: pushed %0d, required %0d", i, blk.size());
        end
    endtask

    task automatic collect(input int rpct);
        int got = 0, cyc = 0, n;
        logic pv = 0, pr = 0, pl = 0;
        logic [127:0] pd = '0;
        n = exp_d.size();
        while (got < n && cyc < 5000) begin
            @(negedge Clk);
            cyc++;
            out_ready = ($urandom_range(99) < rpct);
            #3;
            if (pv && !pr) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
                    n_bad++;
                    $display("FAIL out_hold: valid=%b data=%h last=%b, required 1 %h %b", out_valid, out_data, out_last, pd, pl);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out_data !== exp_d[got] || out_last !== exp_l[got]) begin
                    n_bad++;
                    $display("FAIL out_block%0d: got %h last=%b, required %h last=%b", got, out_data, out_last, exp_d[got], exp_l[got]);
                end
                got++;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
        end
        @(negedge Clk);
        out_ready = 0;
        n_cmp++;
        if (got != n) begin
            n_bad++;
            $display("FAIL collect_timeout: got %0d blocks, required %0d", got, n);
        end
    endtask

    task automatic run_msg(input logic [1:0] m, input logic e, input logic [255:0] k, input logic [127:0] v,
                           input int vpct, input int rpct);
        do_start(m, e, k, v);
        fork
            drive(vpct);
            collect(rpct);
        join
        #3;
        n_cmp++;
        if (busy !== 1'b0 || cfg_err !== 1'b0) begin
            n_bad++;
            $display("FAIL msg_end_idle: busy=%b cfg_err=%b, required 0 0", busy, cfg_err);
        end
    endtask

    task automatic test_reset();
        in_valid = 1;
        repeat (2) @(negedge Clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_data, out_last, busy, cfg_err, core_rst_n, core_en,
             core_data_in, core_key, core_encdec} !== '0) begin
            n_bad++;
            $display("FAIL reset_values: out_data=%h core_key=%h rdy=%b ov=%b busy=%b", out_data, core_key, in_ready, out_valid, busy);
        end
        Rst = 1;
        @(negedge Clk); #3;
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_no_ready: in_ready=%b busy=%b, required 0 0", in_ready, busy);
        end
        in_valid = 0;
    endtask

    task automatic test_ecb();
        logic [255:0] k;
        for (int e = 0; e < 2; e++) begin
            k = {rnd128(), rnd128()};
            fill_blocks(5);
            build_exp(2'b00, 1'(e), k, rnd128());
            run_msg(2'b00, 1'(e), k, rnd128(), 70, 60);
        end
        fill_blocks(1);
        k = {rnd128(), rnd128()};
        build_exp(2'b00, 1'b1, k, '0);
        run_msg(2'b00, 1'b1, k, '0, 100, 100);
    endtask

    task automatic test_cbc();
        logic [255:0] k;
        logic [127:0] v;
        logic [127:0] pt [$];
        k = {rnd128(), rnd128()};
        v = rnd128();
        fill_blocks(4);
        pt = blk;
        build_exp(2'b01, 1'b1, k, v);
        run_msg(2'b01, 1'b1, k, v, 80, 70);
        // Round trip: decrypting the ciphertext with the same IV must give the plaintext back.
        blk = exp_d;
        exp_d = pt;
        run_msg(2'b01, 1'b0, k, v, 60, 50);
    endtask

    task automatic test_ctr();
`ifdef AES_MODE_CTRL_CTR_EN
        logic [255:0] k;
        k = {rnd128(), rnd128()};
        fill_blocks(3);
        build_exp(2'b10, 1'b0, k, '1);
        run_msg(2'b10, 1'b0, k, '1, 70, 70);
        fill_blocks(4);
        build_exp(2'b10, 1'b1, k, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
        run_msg(2'b10, 1'b1, k, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 90, 80);
`else
        do_start(2'b10, 1'b1, '1, '1);
        #3;
        n_cmp++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ctr_disabled: cfg_err=%b busy=%b, required 1 0", cfg_err, busy);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [255:0] k;
        logic [127:0] held;
        int c = 0, moved = 0;
        k = {rnd128(), rnd128()};
        fill_blocks(FIFO_DEPTH + 2);
        build_exp(2'b00, 1'b1, k, '0);
        do_start(2'b00, 1'b1, k, '0);
        out_ready = 0;
        fork
            drive(100);
            begin
                do begin @(negedge Clk); #3; c++; end while (!out_valid && c < 100);
                held = out_data;
                repeat (20) begin
                    @(negedge Clk); #3;
                    if (out_data !== held || out_valid !== 1'b1) moved++;
                end
                n_cmp++;
                if (moved != 0 || held !== exp_d[0]) begin
                    n_bad++;
                    $display("FAIL stall_hold: data=%h moved=%0d, required %h moved=0", held, moved, exp_d[0]);
                end
                n_cmp++;
                if (in_ready !== 1'b0 || n_pushed != FIFO_DEPTH + 1) begin
                    n_bad++;
                    $display("FAIL stall_full: in_ready=%b pushed=%0d, required 0 %0d", in_ready, n_pushed, FIFO_DEPTH + 1);
                end
                collect(100);
            end
        join
    endtask

    task automatic test_cfg_err();
        logic [255:0] k;
        do_start(2'b11, 1'b1, '1, '0);
        #3;
        n_cmp++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL cfg_err_set: cfg_err=%b busy=%b, required 1 0", cfg_err, busy);
        end
        k = {rnd128(), rnd128()};
        do_start(2'b00, 1'b0, k, '0);
        do_start(2'b11, 1'b1, '1, '0);
        #3;
        n_cmp++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL cfg_err_busy: cfg_err=%b busy=%b, required 0 1", cfg_err, busy);
        end
        fill_blocks(2);
        build_exp(2'b00, 1'b0, k, '0);
        fork
            drive(100);
            collect(100);
        join
    endtask

    task automatic test_reset_mid_run();
        int c = 0;
        do_start(2'b01, 1'b1, {rnd128(), rnd128()}, rnd128());
        @(negedge Clk);
        in_valid = 1; in_data = rnd128(); in_last = 0;
        @(negedge Clk);
        in_valid = 0;
        while (!core_en && c < 50) begin @(negedge Clk); c++; end
        Rst = 0;
        #1;
        n_cmp++;
        if (c >= 50 || {in_ready, out_valid, out_data, out_last, busy, cfg_err, core_rst_n, core_en,
                        core_data_in, core_key, core_encdec} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_run: wait=%0d out_data=%h busy=%b core_key=%h, required all zero", c, out_data, busy, core_key);
        end
        @(negedge Clk);
        Rst = 1;
        // A fresh message must not see any block left over from before the reset.
        fill_blocks(2);
        build_exp(2'b01, 1'b0, 256'h1, 128'h5);
        run_msg(2'b01, 1'b0, 256'h1, 128'h5, 100, 100);
    endtask

    initial begin
        test_reset();
        test_ecb();
        test_cbc();
        test_ctr();
        test_backpressure();
        test_cfg_err();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
